// File: rtl/image_buffer_writer_if.sv
// rtl/image_buffer_writer_if.sv - pixel stream, BRAM write port and reader handoff signals
interface image_buffer_writer_if #(
    parameter int PIXEL_SIZE = 8
);
    logic [PIXEL_SIZE-1:0] pixel_i;
    logic                  pixel_valid_i;
    logic                  stall_o;
    logic [31:0]           bram_address;
    logic [31:0]           bram_wdata;
    logic [3:0]            bram_we;
    logic                  start;
    logic                  image_done;
    logic                  overflow_err;

    modport slave (
        input  pixel_i, pixel_valid_i, image_done,
        output stall_o, bram_address, bram_wdata, bram_we, start, overflow_err
    );

    modport master (
        output pixel_i, pixel_valid_i, image_done,
        input  stall_o, bram_address, bram_wdata, bram_we, start, overflow_err
    );
endinterface

// File: rtl/image_buffer_writer.sv
// rtl/image_buffer_writer.sv - ping-pong image BRAM writer with reader start/done handoff
module image_buffer_writer #(
    parameter int          PIXEL_SIZE = 8,
    parameter int          NUM_PIXELS = 784,
    parameter logic [31:0] BASE_ADDR1 = 32'hB000_0000,
    parameter logic [31:0] BASE_ADDR2 = 32'hB000_1000
) (
    input  logic                   clk,
    input  logic                   reset,
    image_buffer_writer_if.slave   bus
);
    typedef enum logic [1:0] {H_IDLE, H_START, H_BUSY} h_state_t;

    localparam logic [9:0] LAST_IDX = 10'(NUM_PIXELS - 1);

    h_state_t    r_state;
    h_state_t    w_next_state;
    logic        r_wr_buf;
    logic        r_rd_buf;
    logic [9:0]  r_pixel_count;
    logic [1:0]  r_full;
    logic        r_overflow;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_we;

    logic        w_stall;
    logic        w_accept;
    logic        w_last;
    logic        w_done;
    logic [1:0]  w_set_full;
    logic [1:0]  w_clr_full;

    assign w_stall  = r_full[r_wr_buf];
    assign w_accept = bus.pixel_valid_i & ~w_stall;
    assign w_last   = w_accept & (r_pixel_count == LAST_IDX);
    assign w_done   = (r_state == H_BUSY) & bus.image_done;

    // Set and clear always target different buffers, so a plain OR/AND-NOT merge is safe.
    assign w_set_full = w_last ? (r_wr_buf ? 2'b10 : 2'b01) : 2'b00;
    assign w_clr_full = w_done ? (r_rd_buf ? 2'b10 : 2'b01) : 2'b00;

    assign bus.stall_o      = w_stall;
    assign bus.bram_address = r_addr;
    assign bus.bram_wdata   = r_wdata;
    assign bus.bram_we      = r_we;
    assign bus.overflow_err = r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_buf      <= 1'b0;
            r_rd_buf      <= 1'b0;
            r_pixel_count <= 10'd0;
            r_full        <= 2'b00;
            r_overflow    <= 1'b0;
            r_addr        <= 32'h0;
            r_wdata       <= 32'h0;
            r_we          <= 4'h0;
        end else begin
            r_we   <= w_accept ? 4'hF : 4'h0;
            r_full <= (r_full | w_set_full) & ~w_clr_full;
            if (w_accept) begin
                r_addr        <= (r_wr_buf ? BASE_ADDR2 : BASE_ADDR1) + {20'b0, r_pixel_count, 2'b00};
                r_wdata       <= 32'(bus.pixel_i);
                r_pixel_count <= w_last ? 10'd0 : r_pixel_count + 10'd1;
            end
            if (w_last) begin
                r_wr_buf <= ~r_wr_buf;
            end
            if (w_done) begin
                r_rd_buf <= ~r_rd_buf;
            end
            if (bus.pixel_valid_i & w_stall) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= H_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The last-pixel bypass lets start coincide with the final BRAM write.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            H_IDLE: begin
                if (r_full[r_rd_buf] | (w_last & (r_wr_buf == r_rd_buf))) begin
                    w_next_state = H_START;
                end
            end
            H_START: w_next_state = H_BUSY;
            H_BUSY: begin
                if (bus.image_done) begin
                    w_next_state = H_IDLE;
                end
            end
            default: w_next_state = H_IDLE;
        endcase
    end

    always_comb begin
        bus.start = 1'b0;
        if (r_state == H_START) begin
            bus.start = 1'b1;
        end
    end
endmodule

// File: tb/tb_image_buffer_writer.sv
// tb/tb_image_buffer_writer.sv - scenario and random checks of image_buffer_writer against an image-level model
module tb_image_buffer_writer;
    localparam int NPIX = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    image_buffer_writer_if #(.PIXEL_SIZE(8)) bus ();

    image_buffer_writer #(
        .PIXEL_SIZE(8),
        .NUM_PIXELS(NPIX),
        .BASE_ADDR1(32'hB000_0000),
        .BASE_ADDR2(32'hB000_1000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    int starts_seen;

    // Image-level model: image k goes to buffer k%2; counts of images in/out/started.
    int          m_img_in, m_img_out, m_started, m_acc;
    bit          m_busy, m_we, m_ovf;
    logic [31:0] m_addr, m_data;
    int          ready_c [256];
    int          done_c  [256];

    logic [70:0] exp_vec, obs_vec;
    logic        o_stall, o_start, o_ovf;
    logic [3:0]  o_we;
    logic [31:0] o_addr, o_data;

    function automatic logic [31:0] base_of(input int k);
        return (k % 2 == 1) ? 32'hB000_1000 : 32'hB000_0000;
    endfunction

    function automatic bit m_stall();
        return (m_img_in - m_img_out) == 2;
    endfunction

    function automatic bit m_start_now();
        if (m_busy || m_started >= m_img_in) return 1'b0;
        if (ready_c[m_started] > cyc) return 1'b0;
        if (m_started > 0 && done_c[m_started-1] + 2 > cyc) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        m_img_in = 0; m_img_out = 0; m_started = 0; m_acc = 0;
        m_busy = 0; m_we = 0; m_ovf = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] p, input bit d);
        bit st, sn, acc, dn;
        bus.pixel_valid_i = v;
        bus.pixel_i       = p;
        bus.image_done    = d;
        @(negedge clk);
        st = m_stall();
        sn = m_start_now();
        o_stall = bus.stall_o; o_start = bus.start; o_ovf = bus.overflow_err;
        o_we = bus.bram_we; o_addr = bus.bram_address; o_data = bus.bram_wdata;
        exp_vec = {st, sn, m_ovf, m_we ? 4'hF : 4'h0, m_we ? m_addr : 32'h0, m_we ? m_data : 32'h0};
        obs_vec = {o_stall, o_start, o_ovf, o_we, m_we ? o_addr : 32'h0, m_we ? o_data : 32'h0};
        if (o_start === 1'b1) starts_seen++;
        acc = v && !st;
        dn  = d && m_busy;
        if (v && st) m_ovf = 1;
        m_we = acc;
        if (acc) begin
            m_addr = base_of(m_img_in) + 32'(4 * m_acc);
            m_data = {24'h0, p};
            m_acc++;
            if (m_acc == NPIX) begin
                ready_c[m_img_in] = cyc + 1;
                m_img_in++;
                m_acc = 0;
            end
        end
        if (sn) begin
            m_busy = 1;
            m_started++;
        end
        if (dn) begin
            done_c[m_started-1] = cyc;
            m_busy = 0;
            m_img_out++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        bus.pixel_valid_i = 1'b0;
        bus.image_done    = 1'b0;
        bus.pixel_i       = 8'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.stall_o, bus.start, bus.overflow_err, bus.bram_we} !== 7'h0) begin
            n_fail++; $display("FAIL reset_ctrl got=%h exp=0", {bus.stall_o, bus.start, bus.overflow_err, bus.bram_we});
        end
        n_cmp++;
        if ({bus.bram_address, bus.bram_wdata} !== 64'h0) begin
            n_fail++; $display("FAIL reset_bus got=%h exp=0", {bus.bram_address, bus.bram_wdata});
        end
        hold_reset();
        step(0, 8'h0, 0);
        n_cmp++;
        if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL reset_idle got=%h exp=%h", obs_vec, exp_vec); end
    endtask

    task automatic test_first_image();
        starts_seen = 0;
        for (int i = 0; i < NPIX + 3; i++) begin
            step(i < NPIX, 8'(i), 0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL first_image cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        n_cmp++;
        if (starts_seen !== 1) begin n_fail++; $display("FAIL first_start_count got=%0d exp=1", starts_seen); end
    endtask

    task automatic test_both_full_overflow();
        for (int i = 0; i < NPIX; i++) begin
            step(1, 8'(16 + i), 0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL second_image cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        step(0, 8'h0, 0);
        n_cmp++;
        if (o_stall !== 1'b1) begin n_fail++; $display("FAIL stall_when_full got=%b exp=1", o_stall); end
        step(1, 8'hAA, 0);
        step(0, 8'h0, 0);
        n_cmp++;
        if ({o_stall, o_ovf, o_we} !== 6'b11_0000) begin
            n_fail++; $display("FAIL overflow got=%b exp=110000", {o_stall, o_ovf, o_we});
        end
        step(0, 8'h0, 1);
        step(0, 8'h0, 0);
        n_cmp++;
        if ({o_stall, o_start} !== 2'b00) begin n_fail++; $display("FAIL release_stall got=%b exp=00", {o_stall, o_start}); end
        step(0, 8'h0, 0);
        n_cmp++;
        if (o_start !== 1'b1) begin n_fail++; $display("FAIL start_after_done got=%b exp=1", o_start); end
        step(1, 8'h5C, 0);
        step(0, 8'h0, 0);
        n_cmp++;
        if ({o_we, o_addr, o_data} !== {4'hF, 32'hB000_0000, 32'h0000_005C}) begin
            n_fail++; $display("FAIL third_first_write got=%h exp=%h", {o_we, o_addr, o_data}, {4'hF, 32'hB000_0000, 32'h0000_005C});
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i < NPIX; i++) begin
            step(1, 8'($urandom_range(0, 255)), i == NPIX - 1);
            n_cmp++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL simul_image cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        step(0, 8'h0, 0);
        n_cmp++;
        if ({o_stall, o_start, o_we} !== 6'b00_1111) begin
            n_fail++; $display("FAIL simul_after got=%b exp=001111", {o_stall, o_start, o_we});
        end
        step(0, 8'h0, 0);
        n_cmp++;
        if (o_start !== 1'b1) begin n_fail++; $display("FAIL simul_start got=%b exp=1", o_start); end
    endtask

    task automatic test_reset_mid_image();
        for (int i = 0; i < 7; i++) begin
            step(1, 8'(100 + i), 0);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.stall_o, bus.start, bus.overflow_err, bus.bram_we, bus.bram_address, bus.bram_wdata} !== 71'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs got=%h exp=0",
                {bus.stall_o, bus.start, bus.overflow_err, bus.bram_we, bus.bram_address, bus.bram_wdata});
        end
        hold_reset();
        starts_seen = 0;
        for (int i = 0; i < NPIX + 8; i++) begin
            step(i >= 4 && i < NPIX + 4, 8'(200 + i), 0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            if (i == 5) begin
                n_cmp++;
                if (o_addr !== 32'hB000_0000) begin n_fail++; $display("FAIL after_reset_addr got=%h exp=b0000000", o_addr); end
            end
        end
        n_cmp++;
        if (starts_seen !== 1) begin n_fail++; $display("FAIL after_reset_starts got=%0d exp=1", starts_seen); end
    endtask

    task automatic test_stray_done();
        reset = 1'b1;
        hold_reset();
        starts_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 8'h0, 1);
            n_cmp++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL stray_done cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        for (int i = 0; i < NPIX + 3; i++) begin
            step(i < NPIX, 8'(i * 3), 0);
            n_cmp++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL stray_image cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
        n_cmp++;
        if (starts_seen !== 1) begin n_fail++; $display("FAIL stray_starts got=%0d exp=1", starts_seen); end
    endtask

    task automatic test_random();
        bit v, d;
        reset = 1'b1;
        hold_reset();
        for (int i = 0; i < 1200; i++) begin
            v = m_stall() ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
            d = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            step(v, 8'($urandom_range(0, 255)), d);
            n_cmp++;
            if (obs_vec !== exp_vec) begin n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
        end
    endtask

    initial begin
        bus.pixel_valid_i = 1'b0;
        bus.pixel_i       = 8'h0;
        bus.image_done    = 1'b0;
        model_clear();
        test_reset();
        test_first_image();
        test_both_full_overflow();
        test_simultaneous();
        test_reset_mid_image();
        test_stray_done();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/image_buffer_writer.md
Name: image_buffer_writer

Overview:
- Write side of the ping-pong image BRAM that the crop/resize reader drains.
- Accepts the pixel stream from the preceding augmentation stage and writes one pixel per 32-bit word into buffer 0 (BASE_ADDR1) or buffer 1 (BASE_ADDR2), alternating, starting with buffer 0.
- Issues a one-cycle start to the reader per completed image, releases the buffer on the reader's image_done, and backpressures upstream when both buffers are full.

Parameters:
- PIXEL_SIZE, 8, pixel width in bits (stored in word LSBs).
- NUM_PIXELS, 784, pixels per image (28x28).
- BASE_ADDR1, 32'hB000_0000, byte base address of buffer 0.
- BASE_ADDR2, 32'hB000_1000, byte base address of buffer 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- pixel_i  in  PIXEL_SIZE  incoming pixel.
- pixel_valid_i  in  1  pixel_i valid this cycle.
- stall_o  out  1  upstream must not send; a pixel offered while high is dropped.
- bram_address  out  32  write byte address.
- bram_wdata  out  32  write data, {zero-extend, pixel}.
- bram_we  out  4  byte write enables, 4'hF on write, else 4'h0.
- start  out  1  one-cycle pulse: an image is complete in the buffer the reader reads next.
- image_done  in  1  reader finished the handed-off buffer; the buffer is free.
- overflow_err  out  1  sticky: pixel offered while stall_o was high.

Behaviour:
- Reset: all outputs 0; wr_buf=0, rd_buf=0, pixel_count=0, full[1:0]=0, handoff FSM in H_IDLE.
- Write path:
  - stall_o = full[wr_buf], combinational from registers.
  - Accept = pixel_valid_i & !stall_o.
  - On accept, next cycle (latency 1, registered): bram_we=4'hF, bram_address = base(wr_buf) + 4*pixel_count, bram_wdata = {24'b0, pixel_i}.
  - pixel_count is 10 bits and increments on each accept.
- Last pixel:
  - On accept with pixel_count==NUM_PIXELS-1: pixel_count<=0, full[wr_buf]<=1, wr_buf<=~wr_buf.
  - The final write still issues normally on the next cycle.
- Handoff FSM:
  - H_IDLE: if full[rd_buf], go to H_START.
  - H_START: start=1 for exactly this cycle; go to H_BUSY.
  - H_BUSY: wait for image_done. On image_done: full[rd_buf]<=0, rd_buf<=~rd_buf, go to H_IDLE.
  - image_done outside H_BUSY is ignored.
- Start timing: start is never asserted in the cycle image_done is seen, nor in the cycle after it. The minimum image_done-to-start gap is 2 cycles, so the reader is back in idle when start arrives.
- Write-complete ordering: full is set in the accept cycle and the handoff FSM moves to H_START next cycle. The last BRAM write is therefore issued in the same cycle as start. The reader's 2-cycle read preamble guarantees the data is stored before it is read.
- Simultaneous events:
  - Last-pixel accept and image_done in the same cycle are independent; they always target different buffers.
  - If image_done frees buffer wr_buf while stall_o was high, stall_o drops on the next cycle.
- Overflow: pixel_valid_i while stall_o=1 sets overflow_err. The pixel is not written and pixel_count does not change. Only reset clears overflow_err.
- Reset mid-image or mid-handoff: all state is discarded immediately and any partial image is lost. No start is issued for it.
- wr_buf and rd_buf never desynchronise: image order out equals image order in.

Test Plan:
- NUM_PIXELS=16, 16 consecutive valid pixels 0..15 -> writes to 0xB000_0000..0xB000_003C with data 0x00..0x0F; start pulses once 1 cycle after the 16th accept; stall_o stays 0.
- Second image 16..31 while the reader is busy -> writes at 0xB000_1000..0xB000_103C; no start until image_done. image_done -> start exactly 2 cycles later; wr_buf returns to buffer 0.
- Third image sent with both buffers full, no image_done -> stall_o=1 after the 32nd accept. A valid pixel 0xAA under stall sets overflow_err=1 and no write occurs. image_done -> stall_o=0 next cycle; the next pixel goes to 0xB000_0000.
- Last pixel of image 2 accepted in the same cycle as image_done for image 1 -> full[0]=0 and full[1]=1; the start for buffer 1 follows 2 cycles later.
- reset asserted after 7 pixels of an image -> all outputs 0 immediately, no start. The next image starts at 0xB000_0000 with pixel_count=0.
- image_done pulse while in H_IDLE with nothing handed off -> no change to full, rd_buf or start.
